fc_tile_controller: RTL and testbench



---
 rtl/fc_pkg.sv | 27 ++
 rtl/fc_tile_counter.sv | 66 ++++++
 rtl/fc_tile_controller.sv | 195 +++++++++++++++++++
 tb/tb_fc_tile_controller.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// fc_pkg: shared types, default sizing constants and width helpers for the
// FC tile controller. Imported by fc_tile_counter and fc_tile_controller.
package fc_pkg;

  // Sequencer states; the controller mirrors these as logic [1:0] constants.
  typedef enum logic [1:0] {
    FC_IDLE     = 2'd0,
    FC_IF_LOAD  = 2'd1,
    FC_W_STREAM = 2'd2,
    FC_DRAIN    = 2'd3
  } fc_state_t;

  localparam int FC_PE_ROWS_DEF = 128;
  localparam int FC_IN_MAX_DEF  = 512;
  localparam int FC_OUT_MAX_DEF = 128;

  // Width of a counter that must hold the value n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of an index into n entries (0..n-1), never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_tile_counter.sv
// fc_tile_counter: tracks the current row tile of a layer, its base ifmap
// address and how many rows it carries (a full PE_ROWS, or the remainder on
// the final tile). The base address for the next cycle is exported so the
// controller can register the ifmap pointer without an extra pipeline stage.
module fc_tile_counter
  import fc_pkg::*;
#(
  parameter  int PE_ROWS = FC_PE_ROWS_DEF,
  parameter  int IN_MAX  = FC_IN_MAX_DEF,
  localparam int IN_W    = cnt_w(IN_MAX),
  localparam int TILE_W  = ptr_w(IN_MAX / PE_ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [IN_W-1:0]   in_nodes_i,
  input  logic              advance_i,
  output logic [TILE_W-1:0] tile_o,
  output logic [IN_W-1:0]   base_next_o,
  output logic [IN_W-1:0]   rows_o,
  output logic              last_o
);

  localparam logic [IN_W-1:0] ROWS_C = IN_W'(PE_ROWS);

  logic [IN_W-1:0]   in_reg;
  logic [IN_W-1:0]   base_reg;
  logic [IN_W-1:0]   base_next;
  logic [IN_W-1:0]   remaining;
  logic [TILE_W-1:0] tile_reg;
  logic [TILE_W-1:0] tile_next;

  // Next tile/base: restart on a new layer, step one tile on advance.
  always_comb begin
    tile_next = tile_reg;
    base_next = base_reg;
    if (load_i) begin
      tile_next = '0;
      base_next = '0;
    end else if (advance_i) begin
      tile_next = tile_reg + TILE_W'(1);
      base_next = base_reg + ROWS_C;
    end
    remaining = in_reg - base_reg;
  end

  // Rows still unread decide both the tile height and whether it is the last.
  assign rows_o      = (remaining > ROWS_C) ? ROWS_C : remaining;
  assign last_o      = (remaining <= ROWS_C);
  assign tile_o      = tile_reg;
  assign base_next_o = base_next;

  // Tile state registers; the layer input count is captured on load only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_reg   <= '0;
      base_reg <= '0;
      tile_reg <= '0;
    end else begin
      if (load_i) in_reg <= in_nodes_i;
      base_reg <= base_next;
      tile_reg <= tile_next;
    end
  end

endmodule

// File: rtl/fc_tile_controller.sv
// fc_tile_controller: FC-layer sequencer for the systolic PE array. Splits the
// input vector into PE_ROWS-high row tiles; per tile it loads the ifmap rows,
// streams one weight column per output node, then drains the array while the
// per-tile partial sums emerge. Optional bias-fetch sequencing is enabled by
// defining FC_BIAS_EN. All outputs are registered from next-state values so
// they line up with the state they describe.
module fc_tile_controller
  import fc_pkg::*;
#(
  parameter  int PE_ROWS = FC_PE_ROWS_DEF,
  parameter  int IN_MAX  = FC_IN_MAX_DEF,
  parameter  int OUT_MAX = FC_OUT_MAX_DEF,
  localparam int IN_W    = cnt_w(IN_MAX),
  localparam int OUT_W   = cnt_w(OUT_MAX),
  localparam int IPTR_W  = ptr_w(IN_MAX),
  localparam int WPTR_W  = ptr_w(OUT_MAX),
  localparam int TILE_W  = ptr_w(IN_MAX / PE_ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [IN_W-1:0]   in_node_num_i,
  input  logic [OUT_W-1:0]  out_node_num_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              ifmap_rden_o,
  output logic [IPTR_W-1:0] ifmap_rdptr_o,
  output logic              pe_load_o,
  output logic              wbuf_rden_o,
  output logic [WPTR_W-1:0] wbuf_rdptr_o,
  output logic [TILE_W-1:0] wbuf_tile_o,
  output logic              rst_buf_n_o,
  output logic              psum_valid_o,
  output logic              acc_first_o,
  output logic              valid_o,
`ifdef FC_BIAS_EN
  output logic              bias_rden_o,
  output logic [WPTR_W-1:0] bias_rdptr_o,
`endif
  output logic              last_o
);

  localparam int PH_W = cnt_w(PE_ROWS + OUT_MAX);

  localparam logic [1:0] IDLE     = FC_IDLE;
  localparam logic [1:0] IF_LOAD  = FC_IF_LOAD;
  localparam logic [1:0] W_STREAM = FC_W_STREAM;
  localparam logic [1:0] DRAIN    = FC_DRAIN;

  localparam logic [PH_W-1:0] PH_ONE       = PH_W'(1);
  localparam logic [PH_W-1:0] PH_PE        = PH_W'(PE_ROWS);
  localparam logic [PH_W-1:0] PH_DRAIN_END = PH_W'(PE_ROWS - 1);

  logic [1:0]        state_reg, state_next;
  logic [PH_W-1:0]   phase_reg, phase_next;
  logic [OUT_W-1:0]  out_reg;
  logic              cfg_ok, accept, phase_end, advance, finish;
  logic [TILE_W-1:0] tile;
  logic [IN_W-1:0]   tile_base_next, tile_rows;
  logic              tile_last;
  logic              in_stream;
  logic [PH_W-1:0]   elapsed, node;
  logic              in_window;

  fc_tile_counter #(
    .PE_ROWS (PE_ROWS),
    .IN_MAX  (IN_MAX)
  ) u_tile (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept),
    .in_nodes_i  (in_node_num_i),
    .advance_i   (advance),
    .tile_o      (tile),
    .base_next_o (tile_base_next),
    .rows_o      (tile_rows),
    .last_o      (tile_last)
  );

  // Config legality and phase-end detection for the current state.
  always_comb begin
    cfg_ok = (in_node_num_i != '0) && (in_node_num_i <= IN_W'(IN_MAX)) &&
             (out_node_num_i != '0) && (out_node_num_i <= OUT_W'(OUT_MAX));
    accept = (state_reg == IDLE) && start_i && cfg_ok;
    case (state_reg)
      IF_LOAD:  phase_end = (phase_reg == PH_W'(tile_rows - IN_W'(1)));
      W_STREAM: phase_end = (phase_reg == PH_W'(out_reg - OUT_W'(1)));
      DRAIN:    phase_end = (phase_reg == PH_DRAIN_END);
      default:  phase_end = 1'b0;
    endcase
    advance = (state_reg == DRAIN) && phase_end && !tile_last;
    finish  = (state_reg == DRAIN) && phase_end && tile_last;
  end

  // Next state; the phase counter restarts at zero on every state change.
  always_comb begin
    state_next = state_reg;
    phase_next = '0;
    case (state_reg)
      IDLE:     if (accept) state_next = IF_LOAD;
      IF_LOAD:  if (phase_end) state_next = W_STREAM;
                else phase_next = phase_reg + PH_ONE;
      W_STREAM: if (phase_end) state_next = DRAIN;
                else phase_next = phase_reg + PH_ONE;
      DRAIN:    if (phase_end) state_next = tile_last ? IDLE : IF_LOAD;
                else phase_next = phase_reg + PH_ONE;
      default:  state_next = IDLE;
    endcase
  end

  // Cycles since W_STREAM entry locate the psum window, which may straddle
  // the W_STREAM/DRAIN boundary when out exceeds PE_ROWS.
  always_comb begin
    in_stream = (state_next == W_STREAM) || (state_next == DRAIN);
    elapsed   = (state_next == DRAIN) ? (PH_W'(out_reg) + phase_next) : phase_next;
    in_window = in_stream && (elapsed >= PH_PE) && (elapsed < PH_PE + PH_W'(out_reg));
    node      = elapsed - PH_PE;
  end

  // Sequencer state registers; out count latched with an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      phase_reg <= '0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      if (accept) out_reg <= out_node_num_i;
    end
  end

  // Registered control outputs, decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      ifmap_rden_o  <= 1'b0;
      ifmap_rdptr_o <= '0;
      pe_load_o     <= 1'b0;
      wbuf_rden_o   <= 1'b0;
      wbuf_rdptr_o  <= '0;
      wbuf_tile_o   <= '0;
      rst_buf_n_o   <= 1'b1;
      psum_valid_o  <= 1'b0;
      acc_first_o   <= 1'b0;
      valid_o       <= 1'b0;
      last_o        <= 1'b0;
    end else begin
      busy_o        <= (state_next != IDLE);
      done_o        <= finish;
      err_o         <= (state_reg == IDLE) && start_i && !cfg_ok;
      ifmap_rden_o  <= (state_next == IF_LOAD);
      pe_load_o     <= (state_next == IF_LOAD);
      ifmap_rdptr_o <= (state_next == IF_LOAD) ?
                       IPTR_W'(tile_base_next + IN_W'(phase_next)) : '0;
      wbuf_rden_o   <= (state_next == W_STREAM);
      wbuf_rdptr_o  <= (state_next == W_STREAM) ? WPTR_W'(phase_next) : '0;
      wbuf_tile_o   <= (state_next == W_STREAM) ? tile : '0;
      rst_buf_n_o   <= (state_next != DRAIN);
      psum_valid_o  <= in_window;
      acc_first_o   <= in_window && (tile == '0);
      valid_o       <= in_window && tile_last;
      last_o        <= in_window && tile_last && (node == PH_W'(out_reg) - PH_ONE);
    end
  end

`ifdef FC_BIAS_EN
  localparam logic [PH_W-1:0] PH_PE_M1 = PH_W'(PE_ROWS - 1);

  logic            bias_window;
  logic [PH_W-1:0] bias_node;

  // Bias reads run one cycle ahead of valid_o so buffer data meets it.
  always_comb begin
    bias_node   = elapsed - PH_PE_M1;
    bias_window = in_stream && tile_last && (elapsed >= PH_PE_M1) &&
                  (elapsed < PH_PE_M1 + PH_W'(out_reg));
  end

  // Registered bias read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_rden_o  <= 1'b0;
      bias_rdptr_o <= '0;
    end else begin
      bias_rden_o  <= bias_window;
      bias_rdptr_o <= bias_window ? WPTR_W'(bias_node) : '0;
    end
  end
`endif

endmodule

// File: tb/tb_fc_tile_controller.sv
// tb_fc_tile_controller: scoreboard bench. Each layer run pushes the expected
// ifmap, weight, drain and psum transactions (with their cycle offsets from
// start) into queues; the per-cycle monitor pops and compares them as the
// DUT strobes. Prints one line per layer run.
`timescale 1ns/1ps
module tb_fc_tile_controller;

  localparam int PE      = 128;
  localparam int IN_MAX  = 512;
  localparam int OUT_MAX = 128;
  localparam logic [63:0] RST_VEC = 64'd16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i = 1'b0;
  logic [9:0] in_node_num_i = '0;
  logic [7:0] out_node_num_i = '0;
  logic       busy_o, done_o, err_o, ifmap_rden_o, pe_load_o, wbuf_rden_o;
  logic [8:0] ifmap_rdptr_o;
  logic [6:0] wbuf_rdptr_o;
  logic [1:0] wbuf_tile_o;
  logic       rst_buf_n_o, psum_valid_o, acc_first_o, valid_o, last_o;
`ifdef FC_BIAS_EN
  logic       bias_rden_o;
  logic [6:0] bias_rdptr_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] ifq[$];
  logic [63:0] wq[$];
  logic [63:0] dq[$];
  logic [63:0] pq[$];
  logic [63:0] bq[$];

  fc_tile_controller #(
    .PE_ROWS (PE),
    .IN_MAX  (IN_MAX),
    .OUT_MAX (OUT_MAX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .in_node_num_i  (in_node_num_i),
    .out_node_num_i (out_node_num_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .ifmap_rden_o   (ifmap_rden_o),
    .ifmap_rdptr_o  (ifmap_rdptr_o),
    .pe_load_o      (pe_load_o),
    .wbuf_rden_o    (wbuf_rden_o),
    .wbuf_rdptr_o   (wbuf_rdptr_o),
    .wbuf_tile_o    (wbuf_tile_o),
    .rst_buf_n_o    (rst_buf_n_o),
    .psum_valid_o   (psum_valid_o),
    .acc_first_o    (acc_first_o),
    .valid_o        (valid_o),
`ifdef FC_BIAS_EN
    .bias_rden_o    (bias_rden_o),
    .bias_rdptr_o   (bias_rdptr_o),
`endif
    .last_o         (last_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {a[15:0], b[15:0], c[15:0], d[15:0]};
  endfunction

  function automatic logic [63:0] outs_vec();
    return 64'({busy_o, done_o, err_o, ifmap_rden_o, ifmap_rdptr_o, pe_load_o,
                wbuf_rden_o, wbuf_rdptr_o, wbuf_tile_o, rst_buf_n_o,
                psum_valid_o, acc_first_o, valid_o, last_o});
  endfunction

  task automatic pop_cmp(input string tag, inout logic [63:0] q[$], input logic [63:0] obs);
    logic [63:0] exp;
    if (q.size() > 0) exp = q.pop_front();
    else exp = '1;
    check(tag, obs, exp);
  endtask

  task automatic run_layer(input int n_in, input int n_out);
    int c, t_cnt, rows, e, rel, total, busy_cnt, drain_cnt, err_cnt, vl;
    logic prev_rb, got_done;
    ifq.delete(); wq.delete(); dq.delete(); pq.delete(); bq.delete();
    t_cnt = (n_in + PE - 1) / PE;
    c = 0;
    for (int t = 0; t < t_cnt; t++) begin
      rows = (n_in - t * PE > PE) ? PE : n_in - t * PE;
      for (int k = 0; k < rows; k++) ifq.push_back(pk(c + k, t * PE + k, 1, 1));
      e = c + rows;
      for (int j = 0; j < n_out; j++) wq.push_back(pk(e + j, t, j, 0));
      dq.push_back(pk(e + n_out, 0, 0, 0));
      for (int j = 0; j < n_out; j++) begin
        vl = ((t == t_cnt - 1) ? 2 : 0) + ((t == t_cnt - 1 && j == n_out - 1) ? 1 : 0);
        pq.push_back(pk(e + PE + j, 1, (t == 0) ? 1 : 0, vl));
        if (t == t_cnt - 1) bq.push_back(pk(e + PE - 1 + j, j, 0, 0));
      end
      c = e + n_out + PE;
    end
    total = c;

    @(negedge clk);
    start_i = 1'b1; in_node_num_i = 10'(n_in); out_node_num_i = 8'(n_out);
    @(negedge clk);
    start_i = 1'b0;
    rel = 0; prev_rb = 1'b1; got_done = 1'b0;
    busy_cnt = 0; drain_cnt = 0; err_cnt = 0;
    while (!got_done && rel <= total + 20) begin
      if (ifmap_rden_o || pe_load_o)
        pop_cmp("ifmap", ifq, pk(rel, int'(ifmap_rdptr_o), int'(ifmap_rden_o), int'(pe_load_o)));
      if (wbuf_rden_o)
        pop_cmp("wbuf", wq, pk(rel, int'(wbuf_tile_o), int'(wbuf_rdptr_o), 0));
      if (!rst_buf_n_o && prev_rb)
        pop_cmp("drain_start", dq, pk(rel, 0, 0, 0));
      if (psum_valid_o || acc_first_o || valid_o || last_o)
        pop_cmp("psum", pq, pk(rel, int'(psum_valid_o), int'(acc_first_o),
                               int'(valid_o) * 2 + int'(last_o)));
`ifdef FC_BIAS_EN
      if (bias_rden_o)
        pop_cmp("bias", bq, pk(rel, int'(bias_rdptr_o), 0, 0));
`endif
      if (busy_o) busy_cnt++;
      if (!rst_buf_n_o) drain_cnt++;
      if (err_o) err_cnt++;
      prev_rb = rst_buf_n_o;
      if (done_o) got_done = 1'b1;
      else begin
        // A start mid-layer, and changed counts, must both be ignored.
        start_i = (rel == 5);
        if (rel == 5) begin
          in_node_num_i = 10'd7; out_node_num_i = 8'd3;
        end
        @(negedge clk);
        rel++;
      end
    end
    start_i = 1'b0;
`ifndef FC_BIAS_EN
    bq.delete();
`endif
    check("done_seen", 64'(got_done), 64'd1);
    check("done_cycle", 64'(rel), 64'(total));
    check("busy_at_done", 64'(busy_o), 64'd0);
    check("busy_cycles", 64'(busy_cnt), 64'(total));
    check("drain_cycles", 64'(drain_cnt), 64'(t_cnt * PE));
    check("no_err", 64'(err_cnt), 64'd0);
    check("queues_empty", 64'(ifq.size() + wq.size() + dq.size() + pq.size() + bq.size()), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(done_o), 64'd0);
    $display("layer in=%0d out=%0d tiles=%0d cycles=%0d checks=%0d passed=%0d",
             n_in, n_out, t_cnt, rel, n_checks, n_pass);
  endtask

  task automatic run_bad(input int n_in, input int n_out);
    int hits, errs;
    @(negedge clk);
    start_i = 1'b1; in_node_num_i = 10'(n_in); out_node_num_i = 8'(n_out);
    @(negedge clk);
    start_i = 1'b0;
    check("err_pulse", 64'(err_o), 64'd1);
    hits = 0; errs = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy_o || ifmap_rden_o || pe_load_o || wbuf_rden_o) hits++;
      @(negedge clk);
      if (err_o) errs++;
    end
    check("err_once", 64'(errs), 64'd0);
    check("bad_cfg_idle", 64'(hits), 64'd0);
    $display("bad config in=%0d out=%0d checks=%0d passed=%0d", n_in, n_out, n_checks, n_pass);
  endtask

  task automatic run_reset_mid();
    int n, flag;
    @(negedge clk);
    start_i = 1'b1; in_node_num_i = 10'd300; out_node_num_i = 8'd84;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!(wbuf_rden_o && wbuf_tile_o == 2'd1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_tile1_wstream", 64'(n < 2000), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outs", outs_vec(), RST_VEC);
`ifdef FC_BIAS_EN
    check("async_reset_bias", 64'({bias_rden_o, bias_rdptr_o}), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    flag = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_o || busy_o) flag++;
    end
    check("no_done_after_reset", 64'(flag), 64'd0);
    $display("mid-layer reset checks=%0d passed=%0d", n_checks, n_pass);
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_outs", outs_vec(), RST_VEC);
`ifdef FC_BIAS_EN
    check("reset_bias", 64'({bias_rden_o, bias_rdptr_o}), 64'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_layer(100, 10);
    run_layer(300, 84);
    run_layer(256, 1);
    run_bad(0, 5);
    run_bad(5, 0);
    run_bad(513, 5);
    run_bad(5, 129);
    run_reset_mid();
    run_layer(16, 4);
    run_layer(512, 128);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
